// File: rtl/sys_defs.sv
// sys_defs: shared fetch types and defaults for the fetch PC generator and its queue.
package sys_defs;
  localparam int FQ_DEPTH_DEF = 4;
  localparam int GH_DEF = 8;
  // Widest history the queue entry can carry; narrower GH is zero-extended.
  localparam int GH_MAX = 32;
  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0]       inst;
    logic              pred_taken;
    logic [31:0]       pred_target;
    logic [GH_MAX-1:0] ghr;
    logic              filled;
  } fetch_entry_t;
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h3;
  endfunction
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: circular fetch queue; entries are allocated at issue and filled in order as
// instruction words return, so decode only sees the head once its word has arrived.
module fetch_queue import sys_defs::*; #(
  parameter int DEPTH = FQ_DEPTH_DEF,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t push_entry_i,
  input  logic         fill_i,
  input  logic [31:0]  fill_inst_i,
  input  logic         pop_i,
  output logic [CW-1:0] count_o,
  output fetch_entry_t head_o
);
  fetch_entry_t mem_q [DEPTH];
  logic [PW-1:0] head_q, tail_q, fill_q;
  logic [CW-1:0] count_q;
  assign count_o = count_q;
  assign head_o = mem_q[head_q];
  // Fill always targets an allocated, unfilled entry, so it never collides with push or pop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q <= '0;
      tail_q <= '0;
      fill_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      head_q <= '0;
      tail_q <= '0;
      fill_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i].filled <= 1'b0;
    end else begin
      if (push_i) begin
        mem_q[tail_q] <= push_entry_i;
        tail_q <= tail_q + PW'(1);
      end
      if (fill_i) begin
        mem_q[fill_q].inst <= fill_inst_i;
        mem_q[fill_q].filled <= 1'b1;
        fill_q <= fill_q + PW'(1);
      end
      if (pop_i) head_q <= head_q + PW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end
endmodule

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: next-PC generation, fetch issue with predictor consult, and discard of
// responses still in flight when the retire stage redirects.
module fetch_pc_gen import sys_defs::*; #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int FQ_DEPTH = FQ_DEPTH_DEF,
  parameter int GH = GH_DEF
) (
  input  logic          clock,
  input  logic          reset_n,
  output logic          imem_req_valid_o,
  output logic [31:0]   imem_req_addr_o,
  input  logic          imem_req_ready_i,
  input  logic          imem_resp_valid_i,
  input  logic [31:0]   imem_resp_data_i,
  output logic          predict_req_valid_o,
  output logic [31:0]   predict_req_pc_o,
  output logic          predict_req_used_o,
  input  logic          predict_taken_i,
  input  logic [31:0]   predict_target_i,
  input  logic [GH-1:0] predict_ghr_snapshot_i,
  input  logic          redirect_valid_i,
  input  logic [31:0]   redirect_pc_i,
  output logic          decode_valid_o,
  input  logic          decode_ready_i,
  output logic [31:0]   decode_pc_o,
  output logic [31:0]   decode_inst_o,
  output logic          decode_pred_taken_o,
  output logic [31:0]   decode_pred_target_o,
  output logic [GH-1:0] decode_ghr_o
);
  localparam int CW = $clog2(FQ_DEPTH) + 1;
  logic [31:0] pc_q, pc_d;
  logic [CW-1:0] out_q, out_d, drop_q, drop_d, count;
  logic taken, fire, resp, fill, dv;
  fetch_entry_t head, push_entry;
  // A zero target is a BTB miss, so a taken prediction without a target falls through.
  always_comb begin
    taken = predict_taken_i && predict_target_i != '0;
    imem_req_valid_o = reset_n && !redirect_valid_i && out_q < CW'(FQ_DEPTH) && count < CW'(FQ_DEPTH);
    fire = imem_req_valid_o && imem_req_ready_i;
    resp = imem_resp_valid_i && out_q != '0;
    fill = resp && !redirect_valid_i && drop_q == '0;
    out_d = out_q + CW'(fire) - CW'(resp);
    drop_d = redirect_valid_i ? out_q - CW'(resp) : drop_q - CW'(resp && drop_q != '0);
    pc_d = redirect_valid_i ? word_align(redirect_pc_i) :
           !fire ? pc_q :
           taken ? word_align(predict_target_i) : pc_q + 32'd4;
    push_entry = '{pc: pc_q, inst: '0, pred_taken: taken, pred_target: predict_target_i,
                   ghr: GH_MAX'(predict_ghr_snapshot_i), filled: 1'b0};
    dv = count != '0 && head.filled;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q <= RESET_PC;
      out_q <= '0;
      drop_q <= '0;
    end else begin
      pc_q <= pc_d;
      out_q <= out_d;
      drop_q <= drop_d;
    end
  end
  fetch_queue #(.DEPTH(FQ_DEPTH)) u_fq (
    .clock        (clock),
    .reset_n      (reset_n),
    .flush_i      (redirect_valid_i),
    .push_i       (fire),
    .push_entry_i (push_entry),
    .fill_i       (fill),
    .fill_inst_i  (imem_resp_data_i),
    .pop_i        (dv && decode_ready_i),
    .count_o      (count),
    .head_o       (head)
  );
  assign imem_req_addr_o = pc_q;
  assign predict_req_valid_o = imem_req_valid_o;
  assign predict_req_pc_o = pc_q;
  assign predict_req_used_o = fire;
  assign decode_valid_o = dv;
  assign decode_pc_o = dv ? head.pc : '0;
  assign decode_inst_o = dv ? head.inst : '0;
  assign decode_pred_taken_o = dv && head.pred_taken;
  assign decode_pred_target_o = dv ? head.pred_target : '0;
  assign decode_ghr_o = dv ? GH'(head.ghr) : '0;
endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen: randomized and directed checks of fetch_pc_gen against a queue-based reference model.
module tb_fetch_pc_gen;
  localparam int D = 4;
  logic clock = 1'b0, reset_n = 1'b0;
  logic imem_req_valid_o, imem_req_ready_i = 1'b0, imem_resp_valid_i = 1'b0;
  logic [31:0] imem_req_addr_o, imem_resp_data_i = '0;
  logic predict_req_valid_o, predict_req_used_o, predict_taken_i = 1'b0;
  logic [31:0] predict_req_pc_o, predict_target_i = '0;
  logic [7:0] predict_ghr_snapshot_i = '0, decode_ghr_o;
  logic redirect_valid_i = 1'b0, decode_valid_o, decode_ready_i = 1'b0, decode_pred_taken_o;
  logic [31:0] redirect_pc_i = '0, decode_pc_o, decode_inst_o, decode_pred_target_o;

  fetch_pc_gen dut (
    .clock(clock), .reset_n(reset_n),
    .imem_req_valid_o(imem_req_valid_o), .imem_req_addr_o(imem_req_addr_o), .imem_req_ready_i(imem_req_ready_i),
    .imem_resp_valid_i(imem_resp_valid_i), .imem_resp_data_i(imem_resp_data_i),
    .predict_req_valid_o(predict_req_valid_o), .predict_req_pc_o(predict_req_pc_o),
    .predict_req_used_o(predict_req_used_o), .predict_taken_i(predict_taken_i),
    .predict_target_i(predict_target_i), .predict_ghr_snapshot_i(predict_ghr_snapshot_i),
    .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
    .decode_valid_o(decode_valid_o), .decode_ready_i(decode_ready_i), .decode_pc_o(decode_pc_o),
    .decode_inst_o(decode_inst_o), .decode_pred_taken_o(decode_pred_taken_o),
    .decode_pred_target_o(decode_pred_target_o), .decode_ghr_o(decode_ghr_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc, inst, tgt;
    logic tk;
    logic [7:0] g;
    logic filled;
  } ment_t;
  typedef struct {
    logic [31:0] pc, inst, tgt;
    logic tk;
  } dlog_t;

  // Model: program-order list of fetched instructions, memory's in-flight address list,
  // count of stale responses still to ignore, and the next fetch PC.
  ment_t mq[$];
  logic [31:0] inflight[$];
  int m_drop = 0;
  logic [31:0] m_pc = '0;
  dlog_t dq[$];
  logic [31:0] fires[$];
  int n_checks = 0, n_fail = 0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic model_reset();
    mq.delete();
    inflight.delete();
    m_drop = 0;
    m_pc = 32'h0;
  endtask

  task automatic step(input logic rdy, input logic tk, input logic [31:0] tgt, input logic rv,
                      input logic [31:0] rpc, input logic drdy, input logic want_resp);
    logic rsp, exp_v, exp_dv, eff;
    logic [7:0] g;
    logic [31:0] rdata;
    ment_t e;
    rsp = want_resp && inflight.size() > 0;
    rdata = rsp ? inst_of(inflight[0]) : $urandom;
    g = 8'($urandom);
    imem_req_ready_i = rdy;
    predict_taken_i = tk;
    predict_target_i = tgt;
    predict_ghr_snapshot_i = g;
    redirect_valid_i = rv;
    redirect_pc_i = rpc;
    decode_ready_i = drdy;
    imem_resp_valid_i = rsp;
    imem_resp_data_i = rdata;
    @(negedge clock);
    exp_v = !rv && (inflight.size() < D) && (mq.size() < D);
    n_checks++;
    if (imem_req_valid_o !== exp_v || predict_req_valid_o !== exp_v) begin
      n_fail++;
      $display("FAIL req_valid: got %b/%b expected %b", imem_req_valid_o, predict_req_valid_o, exp_v);
    end
    n_checks++;
    if (imem_req_addr_o !== m_pc || predict_req_pc_o !== m_pc) begin
      n_fail++;
      $display("FAIL req_addr: got %h/%h expected %h", imem_req_addr_o, predict_req_pc_o, m_pc);
    end
    n_checks++;
    if (predict_req_used_o !== (exp_v && rdy)) begin
      n_fail++;
      $display("FAIL pred_used: got %b expected %b", predict_req_used_o, exp_v && rdy);
    end
    exp_dv = mq.size() > 0 && mq[0].filled;
    e = exp_dv ? mq[0] : '{pc: 32'h0, inst: 32'h0, tgt: 32'h0, tk: 1'b0, g: 8'h0, filled: 1'b0};
    n_checks++;
    if (decode_valid_o !== exp_dv) begin
      n_fail++;
      $display("FAIL decode_valid: got %b expected %b", decode_valid_o, exp_dv);
    end
    n_checks++;
    if (decode_pc_o !== e.pc || decode_inst_o !== e.inst || decode_pred_taken_o !== e.tk ||
        decode_pred_target_o !== e.tgt || decode_ghr_o !== e.g) begin
      n_fail++;
      $display("FAIL decode_data: got pc=%h inst=%h tk=%b tgt=%h g=%h expected pc=%h inst=%h tk=%b tgt=%h g=%h",
               decode_pc_o, decode_inst_o, decode_pred_taken_o, decode_pred_target_o, decode_ghr_o,
               e.pc, e.inst, e.tk, e.tgt, e.g);
    end
    if (exp_dv && drdy)
      dq.push_back('{pc: decode_pc_o, inst: decode_inst_o, tgt: decode_pred_target_o, tk: decode_pred_taken_o});
    if (rsp) begin
      void'(inflight.pop_front());
      if (!rv) begin
        if (m_drop > 0) m_drop--;
        else begin
          for (int i = 0; i < mq.size(); i++) begin
            if (!mq[i].filled) begin
              e = mq[i];
              e.inst = rdata;
              e.filled = 1'b1;
              mq[i] = e;
              break;
            end
          end
        end
      end
    end
    if (exp_dv && drdy) void'(mq.pop_front());
    eff = tk && tgt != 32'h0;
    if (rv) begin
      mq.delete();
      m_drop = inflight.size();
      m_pc = rpc & ~32'h3;
    end else if (exp_v && rdy) begin
      mq.push_back('{pc: m_pc, inst: 32'h0, tgt: tgt, tk: eff, g: g, filled: 1'b0});
      inflight.push_back(m_pc);
      fires.push_back(m_pc);
      m_pc = eff ? (tgt & ~32'h3) : m_pc + 32'd4;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    imem_resp_valid_i = 1'b0;
    redirect_valid_i = 1'b0;
    imem_req_ready_i = 1'b1;
    decode_ready_i = 1'b1;
    #2;
    n_checks++;
    if (imem_req_valid_o !== 1'b0 || predict_req_valid_o !== 1'b0 || predict_req_used_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_req_valid: got %b%b%b expected 000", imem_req_valid_o, predict_req_valid_o, predict_req_used_o);
    end
    n_checks++;
    if (decode_valid_o !== 1'b0 || decode_pred_taken_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_decode_valid: got %b%b expected 00", decode_valid_o, decode_pred_taken_o);
    end
    n_checks++;
    if (decode_pc_o !== 32'h0 || decode_inst_o !== 32'h0 || decode_pred_target_o !== 32'h0 || decode_ghr_o !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_decode_data: got %h %h %h %h expected zeros", decode_pc_o, decode_inst_o, decode_pred_target_o, decode_ghr_o);
    end
    n_checks++;
    if (imem_req_addr_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_pc: got %h expected 00000000", imem_req_addr_o);
    end
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    model_reset();
    dq.delete();
    fires.delete();
  endtask

  task automatic test_sequential();
    test_reset();
    for (int i = 0; i < 12; i++) step(1, 0, 0, 0, 0, 1, 1);
    n_checks++;
    if (fires.size() < 10) begin
      n_fail++;
      $display("FAIL seq_fire_count: got %0d expected >=10", fires.size());
    end
    for (int i = 0; i < fires.size(); i++) begin
      n_checks++;
      if (fires[i] !== 32'(i * 4)) begin
        n_fail++;
        $display("FAIL seq_addr[%0d]: got %h expected %h", i, fires[i], 32'(i * 4));
      end
    end
    n_checks++;
    if (dq.size() < 8) begin
      n_fail++;
      $display("FAIL seq_decode_count: got %0d expected >=8", dq.size());
    end
    for (int i = 0; i < dq.size(); i++) begin
      n_checks++;
      if (dq[i].pc !== 32'(i * 4) || dq[i].inst !== inst_of(32'(i * 4))) begin
        n_fail++;
        $display("FAIL seq_decode[%0d]: got pc=%h inst=%h expected pc=%h inst=%h",
                 i, dq[i].pc, dq[i].inst, 32'(i * 4), inst_of(32'(i * 4)));
      end
    end
  endtask

  task automatic test_predict(input logic [31:0] tgt, input logic [31:0] exp_next, input logic exp_tk);
    int k;
    test_reset();
    k = 0;
    while (k < 40 && imem_req_addr_o !== 32'h40) begin
      step(1, 0, 0, 0, 0, 1, 1);
      k++;
    end
    n_checks++;
    if (imem_req_addr_o !== 32'h40) begin
      n_fail++;
      $display("FAIL pred_reach_40: got %h expected 00000040", imem_req_addr_o);
    end
    dq.delete();
    step(1, 1, tgt, 0, 0, 1, 1);
    n_checks++;
    if (imem_req_addr_o !== exp_next) begin
      n_fail++;
      $display("FAIL pred_next_addr: got %h expected %h", imem_req_addr_o, exp_next);
    end
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0, 1, 1);
    k = -1;
    for (int i = 0; i < dq.size(); i++) if (dq[i].pc === 32'h40 && k < 0) k = i;
    n_checks++;
    if (k < 0 || k + 1 >= dq.size()) begin
      n_fail++;
      $display("FAIL pred_decode_found: got index %0d of %0d expected entry for 00000040 and a successor", k, dq.size());
    end else begin
      n_checks++;
      if (dq[k].tk !== exp_tk || dq[k].tgt !== tgt) begin
        n_fail++;
        $display("FAIL pred_decode_meta: got tk=%b tgt=%h expected tk=%b tgt=%h", dq[k].tk, dq[k].tgt, exp_tk, tgt);
      end
      n_checks++;
      if (dq[k + 1].pc !== exp_next) begin
        n_fail++;
        $display("FAIL pred_decode_next: got %h expected %h", dq[k + 1].pc, exp_next);
      end
    end
  endtask

  task automatic test_full();
    int f;
    test_reset();
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0, 0, 1);
    f = fires.size();
    n_checks++;
    if (f != 4) begin
      n_fail++;
      $display("FAIL full_fire_count: got %0d expected 4", f);
    end
    n_checks++;
    if (imem_req_valid_o !== 1'b0 || imem_req_addr_o !== 32'h10) begin
      n_fail++;
      $display("FAIL full_hold: got valid=%b addr=%h expected valid=0 addr=00000010", imem_req_valid_o, imem_req_addr_o);
    end
  endtask

  task automatic test_redirect();
    test_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 32'h203, 0, 0);
    n_checks++;
    if (imem_req_addr_o !== 32'h200) begin
      n_fail++;
      $display("FAIL redir_pc: got %h expected 00000200", imem_req_addr_o);
    end
    dq.delete();
    for (int i = 0; i < 12; i++) step(1, 0, 0, 0, 0, 1, 1);
    n_checks++;
    if (dq.size() == 0 || dq[0].pc !== 32'h200 || dq[0].inst !== inst_of(32'h200)) begin
      n_fail++;
      $display("FAIL redir_first_decode: got pc=%h expected 00000200", dq.size() ? dq[0].pc : 32'hx);
    end
    for (int i = 0; i < dq.size(); i++) begin
      n_checks++;
      if (dq[i].pc !== 32'h200 + 32'(i * 4)) begin
        n_fail++;
        $display("FAIL redir_stale[%0d]: got %h expected %h", i, dq[i].pc, 32'h200 + 32'(i * 4));
      end
    end
  endtask

  task automatic test_redirect_collide();
    test_reset();
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    dq.delete();
    step(1, 0, 0, 1, 32'h300, 1, 1);
    n_checks++;
    if (dq.size() != 1 || dq[0].pc !== 32'h0 || dq[0].inst !== inst_of(32'h0)) begin
      n_fail++;
      $display("FAIL collide_dequeue: got %0d entries pc=%h expected 1 entry pc=00000000", dq.size(), dq.size() ? dq[0].pc : 32'hx);
    end
    dq.delete();
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0, 1, 1);
    n_checks++;
    if (dq.size() == 0 || dq[0].pc !== 32'h300 || dq[0].inst !== inst_of(32'h300)) begin
      n_fail++;
      $display("FAIL collide_first_decode: got pc=%h inst=%h expected pc=00000300 inst=%h",
               dq.size() ? dq[0].pc : 32'hx, dq.size() ? dq[0].inst : 32'hx, inst_of(32'h300));
    end
  endtask

  task automatic test_random();
    test_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) test_reset();
      step($urandom_range(3, 0) != 0, $urandom_range(2, 0) == 0,
           $urandom_range(3, 0) == 0 ? 32'h0 : $urandom,
           $urandom_range(24, 0) == 0, $urandom,
           $urandom_range(2, 0) != 0, $urandom_range(1, 0) == 1);
    end
  endtask

  initial begin
    @(posedge clock);
    #1;
    test_reset();
    test_sequential();
    test_predict(32'h100, 32'h100, 1'b1);
    test_predict(32'h0, 32'h44, 1'b0);
    test_full();
    test_redirect();
    test_redirect_collide();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
